pc_fetch_sequencer: RTL and testbench
=====================================

Name: pc_fetch_sequencer

Overview:
- Multi-cycle fetch/update controller that owns the program counter.
- Sequences each instruction through three phases: fetch request, wait on instruction memory, execute/commit.
- Issues a read handshake to instruction memory, holds the fetched word stable for the datapath, stalls on data-memory busywait, and updates PC with sequential, branch (BEQ/BNE) or jump targets.
- Sits between instruction memory and the decode/ALU datapath, replacing free-running per-clock PC update.

Parameters:
- RESET_PC, 32'd0, PC value loaded on reset.
- PC_STEP, 32'd4, sequential increment and base for branch targets.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-low reset (0 = reset asserted).
- IMEM_BUSYWAIT  input  1  instruction memory busy; high while a read is in progress.
- INSTRUCTION  input  32  instruction memory read data; valid when IMEM_BUSYWAIT is low.
- DMEM_BUSYWAIT  input  1  data memory busy; stalls commit.
- JUMP  input  1  decoded jump for the current instruction.
- BRANCH  input  1  decoded branch-if-equal.
- BNE  input  1  decoded branch-if-not-equal.
- ZERO  input  1  ALU zero flag for the current instruction.
- OFFSET  input  8  signed word offset from the current instruction.
- PC  output  32  address of the current instruction.
- IMEM_READ  output  1  instruction memory read request.
- INSTR_OUT  output  32  latched instruction presented to decode.
- INSTR_VALID  output  1  high while INSTR_OUT is the live instruction (EXEC state).
- RETIRED  output  32  count of committed instructions.

Behaviour:
- Reset (RESET=0, asynchronous, no clock needed):
  - PC=RESET_PC, IMEM_READ=0, INSTR_OUT=0, INSTR_VALID=0, RETIRED=0, state=IDLE.
  - Reset asserted mid-fetch or mid-stall aborts immediately; no commit.
- State IDLE: first posedge with RESET=1 goes to REQ.
- State REQ: IMEM_READ=1. Next posedge always goes to WAIT; IMEM_BUSYWAIT is ignored in REQ, which gives memory one cycle to raise busywait.
- State WAIT: IMEM_READ=1.
  - Posedge with IMEM_BUSYWAIT=0: INSTR_OUT<=INSTRUCTION, IMEM_READ<=0, INSTR_VALID<=1, go to EXEC.
  - Otherwise stay in WAIT with no bound on the wait length.
- State EXEC: INSTR_VALID=1; INSTR_OUT and PC are held constant.
  - Posedge with DMEM_BUSYWAIT=1: stay in EXEC. Control inputs are ignored during the stall and are re-sampled on the releasing edge.
  - Posedge with DMEM_BUSYWAIT=0 (commit):
    - taken = JUMP | (BRANCH & ZERO) | (BNE & ~ZERO).
    - target = PC + PC_STEP + (sign_extend32(OFFSET) << 2).
    - PC <= taken ? target : PC + PC_STEP.
    - RETIRED <= RETIRED + 1.
    - INSTR_VALID <= 0, go to REQ.
- Arithmetic:
  - All PC arithmetic is 32-bit modulo 2^32; wrap-around is silent (0xFFFFFFFC + 4 = 0).
  - OFFSET range is -128..+127 words.
  - RETIRED wraps from 0xFFFFFFFF to 0.
- Simultaneous JUMP and BRANCH/BNE: the OR already yields taken, and every taken path uses the single target, so no priority logic is needed.
- Latency: minimum 3 cycles per instruction (REQ, WAIT, EXEC) when busywaits are never asserted. Each memory wait cycle adds one cycle.
- No outputs change on the negative clock edge. Outputs carry no combinational path from inputs; IMEM_READ and INSTR_VALID decode from the state register only.

Test Plan:
- Reset, then release with IMEM_BUSYWAIT=0 and no branches:
  - PC reads 0, 4, 8 at commits spaced exactly 3 cycles apart.
  - IMEM_READ high 2 of every 3 cycles.
  - RETIRED=3 after third commit.
- IMEM_BUSYWAIT held high 5 cycles in WAIT:
  - Stays in WAIT with IMEM_READ=1 and INSTR_VALID=0.
  - Latches INSTRUCTION=0xDEADBEEF on release, then INSTR_VALID=1.
- BRANCH=1, ZERO=1, OFFSET=8'hFE at PC=0x10 -> next PC=0x0C. With ZERO=0 -> next PC=0x14. BNE=1, ZERO=0, OFFSET=8'h03 at PC=0x20 -> next PC=0x30.
- DMEM_BUSYWAIT high 4 cycles in EXEC with JUMP=1, OFFSET=8'h01:
  - PC and INSTR_OUT stay constant and RETIRED does not increment during the stall.
  - Commit on release sets PC=old PC+8.
- RESET pulled low asynchronously mid-WAIT at PC=0x40:
  - PC=0, IMEM_READ=0 and INSTR_VALID=0 immediately, without a clock edge.
  - Fetch restarts from 0 after release.
- PC=0xFFFFFFFC with a sequential commit -> PC=0x00000000. RESET_PC=32'h100 override -> first fetch address 0x100.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner: fetch request, imem wait, execute/commit.
// Holds the fetched word for decode and updates PC on commit.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IMEM_BUSYWAIT,
  input  logic [31:0] INSTRUCTION,
  input  logic        DMEM_BUSYWAIT,
  input  logic        JUMP,
  input  logic        BRANCH,
  input  logic        BNE,
  input  logic        ZERO,
  input  logic [7:0]  OFFSET,
  output logic [31:0] PC,
  output logic        IMEM_READ,
  output logic [31:0] INSTR_OUT,
  output logic        INSTR_VALID,
  output logic [31:0] RETIRED
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_EXEC
  } state_t;

  state_t      state;
  logic        taken;
  logic [31:0] seq_pc;
  logic [31:0] target;
  logic [31:0] off_bytes;

  assign taken     = JUMP | (BRANCH & ZERO) | (BNE & ~ZERO);
  assign seq_pc    = PC + PC_STEP;
  assign off_bytes = {{22{OFFSET[7]}}, OFFSET, 2'b00};
  assign target    = seq_pc + off_bytes;

  // IMEM_READ/INSTR_VALID are updated together with state,
  // so they always reflect the registered state.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= S_IDLE;
      PC          <= RESET_PC;
      IMEM_READ   <= 1'b0;
      INSTR_OUT   <= 32'd0;
      INSTR_VALID <= 1'b0;
      RETIRED     <= 32'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          state     <= S_REQ;
          IMEM_READ <= 1'b1;
        end
        S_REQ: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (!IMEM_BUSYWAIT) begin
            state       <= S_EXEC;
            INSTR_OUT   <= INSTRUCTION;
            IMEM_READ   <= 1'b0;
            INSTR_VALID <= 1'b1;
          end
        end
        S_EXEC: begin
          if (!DMEM_BUSYWAIT) begin
            state       <= S_REQ;
            PC          <= taken ? target : seq_pc;
            RETIRED     <= RETIRED + 32'd1;
            INSTR_VALID <= 1'b0;
            IMEM_READ   <= 1'b1;
          end
        end
        default: begin
          state       <= S_IDLE;
          IMEM_READ   <= 1'b0;
          INSTR_VALID <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed steps plus random
// instructions checked against a per-instruction model.
module tb_pc_fetch_sequencer;

  logic        CLK;
  logic        RESET;
  logic        IMEM_BUSYWAIT;
  logic [31:0] INSTRUCTION;
  logic        DMEM_BUSYWAIT;
  logic        JUMP;
  logic        BRANCH;
  logic        BNE;
  logic        ZERO;
  logic [7:0]  OFFSET;
  logic [31:0] PC;
  logic        IMEM_READ;
  logic [31:0] INSTR_OUT;
  logic        INSTR_VALID;
  logic [31:0] RETIRED;

  logic [31:0] pc2;
  logic        rd2;
  logic [31:0] io2;
  logic        vld2;
  logic [31:0] ret2;

  int          vectors = 0;
  int          miscompares = 0;
  int          cycle = 0;
  logic [31:0] m_pc;
  logic [31:0] m_ret;

  pc_fetch_sequencer dut (
    .CLK(CLK), .RESET(RESET),
    .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .INSTRUCTION(INSTRUCTION),
    .DMEM_BUSYWAIT(DMEM_BUSYWAIT), .JUMP(JUMP), .BRANCH(BRANCH),
    .BNE(BNE), .ZERO(ZERO), .OFFSET(OFFSET),
    .PC(PC), .IMEM_READ(IMEM_READ), .INSTR_OUT(INSTR_OUT),
    .INSTR_VALID(INSTR_VALID), .RETIRED(RETIRED)
  );

  pc_fetch_sequencer #(.RESET_PC(32'h100)) dut2 (
    .CLK(CLK), .RESET(RESET),
    .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .INSTRUCTION(INSTRUCTION),
    .DMEM_BUSYWAIT(DMEM_BUSYWAIT), .JUMP(JUMP), .BRANCH(BRANCH),
    .BNE(BNE), .ZERO(ZERO), .OFFSET(OFFSET),
    .PC(pc2), .IMEM_READ(rd2), .INSTR_OUT(io2),
    .INSTR_VALID(vld2), .RETIRED(ret2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cycle <= cycle + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ctrl(input logic j, input logic b, input logic n,
                      input logic z, input logic [7:0] off);
    JUMP = j; BRANCH = b; BNE = n; ZERO = z; OFFSET = off;
  endtask

  // Model: one instruction from REQ back to the next REQ.
  task automatic run_instr(input int iw, input logic [31:0] ins,
                           input int dw, input logic j, input logic b,
                           input logic n, input logic z,
                           input logic [7:0] off);
    int  start;
    int  sx;
    bit  tk;
    start = cycle;
    chk("req_pc", PC, m_pc);
    chk("req_rd", 32'(IMEM_READ), 32'd1);
    chk("req_vld", 32'(INSTR_VALID), 32'd0);
    IMEM_BUSYWAIT = (iw > 0);
    INSTRUCTION = $urandom;
    @(negedge CLK);
    for (int i = 0; i < iw; i++) begin
      chk("wait_rd", 32'(IMEM_READ), 32'd1);
      chk("wait_vld", 32'(INSTR_VALID), 32'd0);
      IMEM_BUSYWAIT = 1'b1;
      INSTRUCTION = $urandom;
      @(negedge CLK);
    end
    chk("wait_rd", 32'(IMEM_READ), 32'd1);
    chk("wait_vld", 32'(INSTR_VALID), 32'd0);
    IMEM_BUSYWAIT = 1'b0;
    INSTRUCTION = ins;
    @(negedge CLK);
    INSTRUCTION = $urandom;
    chk("exec_instr", INSTR_OUT, ins);
    chk("exec_vld", 32'(INSTR_VALID), 32'd1);
    chk("exec_rd", 32'(IMEM_READ), 32'd0);
    chk("exec_pc", PC, m_pc);
    chk("exec_ret", RETIRED, m_ret);
    for (int i = 0; i < dw; i++) begin
      DMEM_BUSYWAIT = 1'b1;
      ctrl(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           8'($urandom));
      @(negedge CLK);
      chk("stall_pc", PC, m_pc);
      chk("stall_instr", INSTR_OUT, ins);
      chk("stall_ret", RETIRED, m_ret);
      chk("stall_vld", 32'(INSTR_VALID), 32'd1);
    end
    DMEM_BUSYWAIT = 1'b0;
    ctrl(j, b, n, z, off);
    @(negedge CLK);
    ctrl(0, 0, 0, 0, 8'h00);
    sx = int'($signed(off));
    tk = j || (b && z) || (n && !z);
    m_pc = tk ? m_pc + 32'(4 + 4 * sx) : m_pc + 32'd4;
    m_ret = m_ret + 32'd1;
    chk("commit_pc", PC, m_pc);
    chk("commit_ret", RETIRED, m_ret);
    chk("latency", 32'(cycle - start), 32'(3 + iw + dw));
  endtask

  initial begin
    RESET = 1'b0;
    IMEM_BUSYWAIT = 1'b0;
    INSTRUCTION = 32'd0;
    DMEM_BUSYWAIT = 1'b0;
    ctrl(0, 0, 0, 0, 8'h00);
    m_pc = 32'd0;
    m_ret = 32'd0;
    repeat (2) @(negedge CLK);
    chk("rst_pc", PC, 32'd0);
    chk("rst_rd", 32'(IMEM_READ), 32'd0);
    chk("rst_instr", INSTR_OUT, 32'd0);
    chk("rst_vld", 32'(INSTR_VALID), 32'd0);
    chk("rst_ret", RETIRED, 32'd0);
    chk("rst_pc2", pc2, 32'h100);
    RESET = 1'b1;
    @(negedge CLK);
    chk("pc2_first_fetch", pc2, 32'h100);
    chk("rd2_first_fetch", 32'(rd2), 32'd1);

    // Sequential stream, then branches from 0x10
    run_instr(0, 32'h11111111, 0, 0, 0, 0, 0, 8'h00);
    run_instr(0, 32'h22222222, 0, 0, 0, 0, 0, 8'h00);
    run_instr(0, 32'h33333333, 0, 0, 0, 0, 0, 8'h00);
    chk("ret_three", RETIRED, 32'd3);
    run_instr(0, 32'h44444444, 0, 0, 0, 0, 0, 8'h00);
    chk("pc_0x10", PC, 32'h10);
    run_instr(5, 32'hDEADBEEF, 0, 0, 1, 0, 1, 8'hFE);
    chk("beq_taken", PC, 32'h0C);
    run_instr(0, 32'h0, 0, 0, 0, 0, 0, 8'h00);
    run_instr(0, 32'h1, 0, 0, 1, 0, 0, 8'hFE);
    chk("beq_not_taken", PC, 32'h14);
    run_instr(0, 32'h2, 0, 1, 0, 0, 0, 8'h02);
    run_instr(0, 32'h3, 0, 0, 0, 1, 0, 8'h03);
    chk("bne_taken", PC, 32'h30);
    run_instr(0, 32'h4, 4, 1, 0, 0, 0, 8'h01);
    chk("jump_after_stall", PC, 32'h38);
    run_instr(0, 32'h5, 0, 1, 0, 0, 0, 8'h01);
    chk("pc_0x40", PC, 32'h40);

    // Asynchronous abort in WAIT
    IMEM_BUSYWAIT = 1'b1;
    repeat (2) @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    chk("async_pc", PC, 32'd0);
    chk("async_rd", 32'(IMEM_READ), 32'd0);
    chk("async_vld", 32'(INSTR_VALID), 32'd0);
    chk("async_ret", RETIRED, 32'd0);
    @(negedge CLK);
    IMEM_BUSYWAIT = 1'b0;
    RESET = 1'b1;
    m_pc = 32'd0;
    m_ret = 32'd0;
    @(negedge CLK);

    // Wrap-around through 0xFFFFFFFC
    run_instr(0, 32'h6, 0, 1, 0, 0, 0, 8'hFE);
    chk("pc_top", PC, 32'hFFFFFFFC);
    run_instr(1, 32'h7, 0, 0, 0, 0, 0, 8'h00);
    chk("pc_wrap", PC, 32'h0);

    for (int k = 0; k < 40; k++) begin
      run_instr(int'($urandom_range(0, 3)), $urandom,
                int'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
